axi_riscv_resv_table: RTL and testbench

Parametrised LR/SC reservation table for the AXI RISC-V atomics path. It tracks up to NUM_RESV concurrent load-reserved reservations, keyed by AXI ID and address granule, and answers store-conditional checks with success or fail. It snoops every accepted write burst on the downstream write path and invalidates any reservation the burst overlaps. Reservations can optionally expire after a cycle timeout. The block sits between the atomics front-end (LR/SC decode) and the AW path, replacing the single-reservation scheme.

---
 rtl/axi_riscv_resv_table.sv | 175 +++++++++++++++++
 tb/tb_axi_riscv_resv_table.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_resv_table.sv
// LR/SC reservation table: tracks up to NUM_RESV reservations keyed by AXI ID and
// address granule, answers SC checks, and invalidates reservations hit by snooped writes.
module axi_riscv_resv_table #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned NUM_RESV     = 4,
    parameter int unsigned GRANULE_LOG2 = 3,
    parameter int unsigned RESV_TIMEOUT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lr_valid_i,
    output logic                  lr_ready_o,
    input  logic [ADDR_WIDTH-1:0] lr_addr_i,
    input  logic [ID_WIDTH-1:0]   lr_id_i,
    input  logic                  sc_valid_i,
    output logic                  sc_ready_o,
    input  logic [ADDR_WIDTH-1:0] sc_addr_i,
    input  logic [ID_WIDTH-1:0]   sc_id_i,
    output logic                  sc_rsp_valid_o,
    input  logic                  sc_rsp_ready_i,
    output logic                  sc_rsp_success_o,
    output logic [ID_WIDTH-1:0]   sc_rsp_id_o,
    input  logic                  wr_valid_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [7:0]            wr_len_i,
    input  logic [2:0]            wr_size_i,
    output logic [NUM_RESV-1:0]   resv_valid_o
);

    localparam int unsigned GW    = ADDR_WIDTH - GRANULE_LOG2;
    localparam int unsigned PTR_W = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;
    localparam int unsigned AGE_W = (RESV_TIMEOUT > 1) ? $clog2(RESV_TIMEOUT) : 1;

    logic [NUM_RESV-1:0] valid_q, valid_d;
    logic [ID_WIDTH-1:0] id_q   [NUM_RESV];
    logic [GW-1:0]       gran_q [NUM_RESV];
    logic [PTR_W-1:0]    rr_q, rr_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_success_q, rsp_success_d;
    logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;

    logic [NUM_RESV-1:0] expire, snoop_hit, survive;
    logic [NUM_RESV-1:0] sc_id_hit, sc_gran_hit, sc_clear;
    logic [NUM_RESV-1:0] lr_match, valid_pre, install;
    logic                sc_accept, sc_success, free_found;

    logic [15:0]         wr_bytes;
    logic [ADDR_WIDTH:0] wr_last;
    logic [GW-1:0]       wr_start, wr_end;
    logic [GW-1:0]       sc_gran, lr_gran;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{sc_addr_i[GRANULE_LOG2-1:0], lr_addr_i[GRANULE_LOG2-1:0]};

    assign lr_ready_o       = 1'b1;
    assign sc_ready_o       = !rsp_valid_q || sc_rsp_ready_i;
    assign sc_accept        = sc_valid_i && sc_ready_o;
    assign sc_rsp_valid_o   = rsp_valid_q;
    assign sc_rsp_success_o = rsp_success_q;
    assign sc_rsp_id_o      = rsp_id_q;
    assign resv_valid_o     = valid_q;

    assign sc_gran = sc_addr_i[ADDR_WIDTH-1:GRANULE_LOG2];
    assign lr_gran = lr_addr_i[ADDR_WIDTH-1:GRANULE_LOG2];

    // Last byte of the burst is computed one bit wider; a carry saturates instead of wrapping.
    assign wr_bytes = ({8'd0, wr_len_i} + 16'd1) << wr_size_i;
    assign wr_last  = {1'b0, wr_addr_i} + (ADDR_WIDTH+1)'(wr_bytes - 16'd1);
    assign wr_start = wr_addr_i[ADDR_WIDTH-1:GRANULE_LOG2];
    assign wr_end   = wr_last[ADDR_WIDTH] ? '1 : wr_last[ADDR_WIDTH-1:GRANULE_LOG2];

    if (RESV_TIMEOUT > 0) begin : g_age
        logic [AGE_W-1:0] age_q [NUM_RESV];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < NUM_RESV; i++) age_q[i] <= '0;
            end else begin
                for (int i = 0; i < NUM_RESV; i++) begin
                    if (install[i])      age_q[i] <= '0;
                    else if (valid_q[i]) age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end

        always_comb begin
            expire = '0;
            for (int i = 0; i < NUM_RESV; i++)
                expire[i] = valid_q[i] && (age_q[i] == AGE_W'(RESV_TIMEOUT - 1));
        end
    end else begin : g_no_age
        assign expire = '0;
    end

    always_comb begin
        snoop_hit   = '0;
        sc_id_hit   = '0;
        sc_gran_hit = '0;
        lr_match    = '0;
        for (int i = 0; i < NUM_RESV; i++) begin
            snoop_hit[i]   = valid_q[i] && wr_valid_i && (gran_q[i] >= wr_start) && (gran_q[i] <= wr_end);
            sc_id_hit[i]   = valid_q[i] && (id_q[i] == sc_id_i);
            sc_gran_hit[i] = valid_q[i] && (gran_q[i] == sc_gran);
            lr_match[i]    = valid_q[i] && (id_q[i] == lr_id_i);
        end
        survive    = valid_q & ~expire & ~snoop_hit;
        sc_success = |(survive & sc_id_hit & sc_gran_hit);
        sc_clear   = sc_accept ? (sc_id_hit | (sc_success ? sc_gran_hit : '0)) : '0;
        valid_pre  = survive & ~sc_clear;

        // LR placement: same-ID slot, else lowest free slot, else round-robin eviction.
        install    = '0;
        rr_d       = rr_q;
        free_found = 1'b0;
        if (lr_valid_i) begin
            if (|lr_match) begin
                install = lr_match;
            end else begin
                for (int i = 0; i < NUM_RESV; i++) begin
                    if (!free_found && !valid_pre[i]) begin
                        install[i] = 1'b1;
                        free_found = 1'b1;
                    end
                end
                if (!free_found) begin
                    install[rr_q] = 1'b1;
                    rr_d = (rr_q == PTR_W'(NUM_RESV - 1)) ? '0 : rr_q + PTR_W'(1);
                end
            end
        end
        valid_d = valid_pre | install;
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_success_d = rsp_success_q;
        rsp_id_d      = rsp_id_q;
        if (sc_accept) begin
            rsp_valid_d   = 1'b1;
            rsp_success_d = sc_success;
            rsp_id_d      = sc_id_i;
        end else if (sc_rsp_ready_i) begin
            rsp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            rr_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_success_q <= 1'b0;
            rsp_id_q      <= '0;
        end else begin
            valid_q       <= valid_d;
            rr_q          <= rr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_success_q <= rsp_success_d;
            rsp_id_q      <= rsp_id_d;
        end
    end

    // Entry payload needs no reset; it is only observed through valid_q.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_RESV; i++) begin
            if (install[i]) begin
                id_q[i]   <= lr_id_i;
                gran_q[i] <= lr_gran;
            end
        end
    end

endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// Directed bench for axi_riscv_resv_table: one instance without expiry, one with an 8-cycle timeout.
module tb_axi_riscv_resv_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lr_valid = 1'b0;
    logic [63:0] lr_addr = '0;
    logic [3:0]  lr_id = '0;
    logic        sc_valid = 1'b0;
    logic [63:0] sc_addr = '0;
    logic [3:0]  sc_id = '0;
    logic        rsp_ready = 1'b1;
    logic        wr_valid = 1'b0;
    logic [63:0] wr_addr = '0;
    logic [7:0]  wr_len = '0;
    logic [2:0]  wr_size = '0;

    logic       lr_ready0, sc_ready0, rsp_valid0, rsp_succ0;
    logic [3:0] rsp_id0, resv0;
    logic       lr_ready8, sc_ready8, rsp_valid8, rsp_succ8;
    logic [3:0] rsp_id8, resv8;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_riscv_resv_table #(.ADDR_WIDTH(64), .ID_WIDTH(4), .NUM_RESV(4), .GRANULE_LOG2(3), .RESV_TIMEOUT(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .lr_valid_i(lr_valid), .lr_ready_o(lr_ready0), .lr_addr_i(lr_addr), .lr_id_i(lr_id),
        .sc_valid_i(sc_valid), .sc_ready_o(sc_ready0), .sc_addr_i(sc_addr), .sc_id_i(sc_id),
        .sc_rsp_valid_o(rsp_valid0), .sc_rsp_ready_i(rsp_ready), .sc_rsp_success_o(rsp_succ0),
        .sc_rsp_id_o(rsp_id0),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_len_i(wr_len), .wr_size_i(wr_size),
        .resv_valid_o(resv0)
    );

    axi_riscv_resv_table #(.ADDR_WIDTH(64), .ID_WIDTH(4), .NUM_RESV(4), .GRANULE_LOG2(3), .RESV_TIMEOUT(8)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .lr_valid_i(lr_valid), .lr_ready_o(lr_ready8), .lr_addr_i(lr_addr), .lr_id_i(lr_id),
        .sc_valid_i(sc_valid), .sc_ready_o(sc_ready8), .sc_addr_i(sc_addr), .sc_id_i(sc_id),
        .sc_rsp_valid_o(rsp_valid8), .sc_rsp_ready_i(rsp_ready), .sc_rsp_success_o(rsp_succ8),
        .sc_rsp_id_o(rsp_id8),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_len_i(wr_len), .wr_size_i(wr_size),
        .resv_valid_o(resv8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic lr(input logic [3:0] id, input logic [63:0] addr);
        lr_valid = 1'b1; lr_id = id; lr_addr = addr;
        step();
        lr_valid = 1'b0;
    endtask

    task automatic sc(input logic [3:0] id, input logic [63:0] addr);
        sc_valid = 1'b1; sc_id = id; sc_addr = addr;
        step();
        sc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (resv0 !== 4'h0) begin n_fail++; $display("FAIL reset_resv: got %h want 0", resv0); end
        n_cmp++; if (rsp_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid0); end
        n_cmp++; if (rsp_succ0 !== 1'b0 || rsp_id0 !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %b/%h want 0/0", rsp_succ0, rsp_id0); end
        n_cmp++; if (lr_ready0 !== 1'b1 || sc_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b/%b want 1/1", lr_ready0, sc_ready0); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lr_sc();
        do_reset();
        lr(4'd1, 64'h1000);
        n_cmp++; if (resv0 !== 4'b0001) begin n_fail++; $display("FAIL lr_install: got %b want 0001", resv0); end
        sc(4'd1, 64'h1004);
        n_cmp++; if (rsp_valid0 !== 1'b1 || rsp_succ0 !== 1'b1 || rsp_id0 !== 4'd1) begin n_fail++;
            $display("FAIL sc_basic: got v%b s%b id%h want v1 s1 id1", rsp_valid0, rsp_succ0, rsp_id0); end
        n_cmp++; if (resv0 !== 4'b0000) begin n_fail++; $display("FAIL sc_clear: got %b want 0000", resv0); end
        step();
        n_cmp++; if (rsp_valid0 !== 1'b0) begin n_fail++; $display("FAIL rsp_drain: got %b want 0", rsp_valid0); end
    endtask

    task automatic test_snoop();
        do_reset();
        lr(4'd2, 64'h2000);
        wr_valid = 1'b1; wr_addr = 64'h1FF8; wr_len = 8'd1; wr_size = 3'd3;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (resv0 !== 4'b0000) begin n_fail++; $display("FAIL snoop_clear: got %b want 0000", resv0); end
        sc(4'd2, 64'h2000);
        n_cmp++; if (rsp_succ0 !== 1'b0 || rsp_id0 !== 4'd2) begin n_fail++;
            $display("FAIL snoop_sc: got s%b id%h want s0 id2", rsp_succ0, rsp_id0); end
        // a burst ending just below the granule must leave it alone
        lr(4'd3, 64'h3000);
        wr_valid = 1'b1; wr_addr = 64'h2FF0; wr_len = 8'd1; wr_size = 3'd3;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (resv0 !== 4'b0001) begin n_fail++; $display("FAIL snoop_edge: got %b want 0001", resv0); end
    endtask

    task automatic test_evict();
        do_reset();
        for (int i = 0; i < 5; i++) lr(4'(i), 64'(i + 1) << 8);
        n_cmp++; if (resv0 !== 4'hF) begin n_fail++; $display("FAIL evict_full: got %h want F", resv0); end
        sc(4'd0, 64'h100);
        n_cmp++; if (rsp_succ0 !== 1'b0) begin n_fail++; $display("FAIL evict_sc_id0: got %b want 0", rsp_succ0); end
        sc(4'd4, 64'h500);
        n_cmp++; if (rsp_succ0 !== 1'b1 || resv0 !== 4'hE) begin n_fail++;
            $display("FAIL evict_sc_id4: got s%b resv %h want s1 resv E", rsp_succ0, resv0); end
        lr(4'd5, 64'h600);
        lr(4'd6, 64'h700);
        sc(4'd1, 64'h200);
        n_cmp++; if (rsp_succ0 !== 1'b0) begin n_fail++; $display("FAIL evict_ptr_id1: got %b want 0", rsp_succ0); end
        sc(4'd6, 64'h700);
        n_cmp++; if (rsp_succ0 !== 1'b1 || resv0 !== 4'hD) begin n_fail++;
            $display("FAIL evict_ptr_id6: got s%b resv %h want s1 resv D", rsp_succ0, resv0); end
    endtask

    task automatic test_timeout();
        do_reset();
        lr(4'd3, 64'h3000);
        repeat (6) step();
        sc(4'd3, 64'h3000);
        n_cmp++; if (rsp_succ8 !== 1'b1) begin n_fail++; $display("FAIL timeout_c7: got %b want 1", rsp_succ8); end
        do_reset();
        lr(4'd3, 64'h3000);
        repeat (7) step();
        sc(4'd3, 64'h3000);
        n_cmp++; if (rsp_succ8 !== 1'b0) begin n_fail++; $display("FAIL timeout_c8: got %b want 0", rsp_succ8); end
        n_cmp++; if (rsp_succ0 !== 1'b1) begin n_fail++; $display("FAIL no_timeout_c8: got %b want 1", rsp_succ0); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        lr(4'd1, 64'h4000);
        wr_valid = 1'b1; wr_addr = 64'h4000; wr_len = 8'd0; wr_size = 3'd0;
        sc(4'd1, 64'h4000);
        wr_valid = 1'b0;
        n_cmp++; if (rsp_succ0 !== 1'b0) begin n_fail++; $display("FAIL snoop_and_sc: got %b want 0", rsp_succ0); end
        wr_valid = 1'b1; wr_addr = 64'h5000;
        lr(4'd2, 64'h5000);
        wr_valid = 1'b0;
        sc(4'd2, 64'h5000);
        n_cmp++; if (rsp_succ0 !== 1'b1) begin n_fail++; $display("FAIL snoop_and_lr: got %b want 1", rsp_succ0); end
        lr(4'd3, 64'h6000);
        lr_valid = 1'b1; lr_id = 4'd3; lr_addr = 64'h7000;
        sc(4'd3, 64'h6000);
        lr_valid = 1'b0;
        n_cmp++; if (rsp_succ0 !== 1'b1 || resv0 !== 4'b0001) begin n_fail++;
            $display("FAIL sc_and_lr: got s%b resv %b want s1 resv 0001", rsp_succ0, resv0); end
        sc(4'd3, 64'h7000);
        n_cmp++; if (rsp_succ0 !== 1'b1) begin n_fail++; $display("FAIL lr_after_sc: got %b want 1", rsp_succ0); end
        do_reset();
        lr(4'd1, 64'h0);
        lr(4'd2, 64'hFFFF_FFFF_FFFF_FFF8);
        wr_valid = 1'b1; wr_addr = 64'hFFFF_FFFF_FFFF_FFF8; wr_len = 8'd3; wr_size = 3'd3;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (resv0 !== 4'b0001) begin n_fail++; $display("FAIL no_wrap: got %b want 0001", resv0); end
        sc(4'd1, 64'h0);
        n_cmp++; if (rsp_succ0 !== 1'b1) begin n_fail++; $display("FAIL no_wrap_sc: got %b want 1", rsp_succ0); end
    endtask

    task automatic test_backpressure();
        do_reset();
        lr(4'd1, 64'h1000);
        lr(4'd2, 64'h2000);
        rsp_ready = 1'b0;
        sc(4'd1, 64'h1000);
        sc_valid = 1'b1; sc_id = 4'd2; sc_addr = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (sc_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0", i, sc_ready0); end
            n_cmp++; if (rsp_valid0 !== 1'b1 || rsp_succ0 !== 1'b1 || rsp_id0 !== 4'd1) begin n_fail++;
                $display("FAIL bp_hold c%0d: got v%b s%b id%h want v1 s1 id1", i, rsp_valid0, rsp_succ0, rsp_id0); end
            step();
        end
        sc_valid = 1'b0;
        n_cmp++; if (resv0 !== 4'b0010) begin n_fail++; $display("FAIL bp_no_accept: got %b want 0010", resv0); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid0 !== 1'b0 || resv0 !== 4'b0000 || sc_ready0 !== 1'b1) begin n_fail++;
            $display("FAIL async_rst: got v%b resv %b rdy %b want v0 resv 0000 rdy 1", rsp_valid0, resv0, sc_ready0); end
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        lr(4'd1, 64'h1000);
        lr(4'd2, 64'h2000);
        sc(4'd1, 64'h1000);
        n_cmp++; if (rsp_succ0 !== 1'b1 || rsp_id0 !== 4'd1) begin n_fail++;
            $display("FAIL b2b_first: got s%b id%h want s1 id1", rsp_succ0, rsp_id0); end
        n_cmp++; if (sc_ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", sc_ready0); end
        sc(4'd2, 64'h2008);
        n_cmp++; if (rsp_valid0 !== 1'b1 || rsp_succ0 !== 1'b0 || rsp_id0 !== 4'd2) begin n_fail++;
            $display("FAIL b2b_second: got v%b s%b id%h want v1 s0 id2", rsp_valid0, rsp_succ0, rsp_id0); end
        n_cmp++; if (resv0 !== 4'b0000) begin n_fail++; $display("FAIL b2b_fail_clears: got %b want 0000", resv0); end
    endtask

    initial begin
        test_reset();
        test_lr_sc();
        test_snoop();
        test_evict();
        test_timeout();
        test_same_cycle();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
